// File: rtl/systolic_pkg.sv
// systolic_pkg: shared defaults, FSM states and lane slicing helper for systolic_feeder.
package systolic_pkg;
  localparam int N_DEF = 4;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DONE} state_t;
  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction
endpackage

// File: rtl/systolic_feeder_skew_line.sv
// skew_line: enable-gated shift register delaying one edge lane by DEPTH advancing cycles.
module skew_line #(
  parameter int DEPTH = 1,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [DEPTH-1:0][W-1:0] sh_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sh_q <= '0;
    else if (clr_i) sh_q <= '0;
    else if (en_i) begin
      sh_q[0] <= d_i;
      for (int k = 1; k < DEPTH; k++) sh_q[k] <= sh_q[k-1];
    end
  assign q_o = sh_q[DEPTH-1];
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: skews A/B wavefronts onto the systolic array edges, sequencing clear, feed, zero flush and done.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int K_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [K_W-1:0]    k_len,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*DATA_W-1:0] a_col,
  input  logic [N*DATA_W-1:0] b_row,
  output logic              arr_en,
  output logic              arr_clr,
  output logic [N*DATA_W-1:0] a_edge,
  output logic [N*DATA_W-1:0] b_edge,
  output logic [15:0]       stall_cnt
);
  localparam int FL_W = $clog2(2 * N) + 1;
  localparam int CNT_W = K_W > FL_W ? K_W : FL_W;
  state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0] stall_q;
  logic accept, advance;
  assign accept = (state_q == FEED) & in_valid;
  assign advance = accept | (state_q == FLUSH);
  // One counter serves both phases: beats left in FEED, flush cycles left in FLUSH.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      stall_q <= '0;
    end else
      case (state_q)
        IDLE: if (start) begin
          state_q <= CLEAR;
          cnt_q <= CNT_W'(k_len);
        end
        CLEAR: begin
          stall_q <= '0;
          state_q <= cnt_q == '0 ? DONE : FEED;
        end
        FEED: if (in_valid) begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= N == 1 ? DONE : FLUSH;
            cnt_q <= CNT_W'(2 * N - 2);
          end
        end else if (stall_q != '1) stall_q <= stall_q + 16'd1;
        FLUSH: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= DONE;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign in_ready = state_q == FEED;
  assign arr_clr = state_q == CLEAR;
  assign arr_en = advance;
  assign stall_cnt = stall_q;
  assign a_edge[DATA_W-1:0] = accept ? a_col[DATA_W-1:0] : '0;
  assign b_edge[DATA_W-1:0] = accept ? b_row[DATA_W-1:0] : '0;
  for (genvar i = 1; i < N; i++) begin : g_lane
    skew_line #(.DEPTH(i), .W(DATA_W)) u_a (
      .clk(clk), .rst_n(rst_n), .clr_i(arr_clr), .en_i(advance),
      .d_i(accept ? a_col[lane_lo(i, DATA_W) +: DATA_W] : '0),
      .q_o(a_edge[lane_lo(i, DATA_W) +: DATA_W])
    );
    skew_line #(.DEPTH(i), .W(DATA_W)) u_b (
      .clk(clk), .rst_n(rst_n), .clr_i(arr_clr), .en_i(advance),
      .d_i(accept ? b_row[lane_lo(i, DATA_W) +: DATA_W] : '0),
      .q_o(b_edge[lane_lo(i, DATA_W) +: DATA_W])
    );
  end
endmodule
